// File: rtl/stacker_pkg.sv
// Shared types and helpers for the stacker game core: FSM states, gamestate
// encodings, popcount and saturating add.
package stacker_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PLACE, EOG} state_e;

  localparam logic [1:0] GS_RUN  = 2'b01;
  localparam logic [1:0] GS_MENU = 2'b00;

  function automatic logic [31:0] popcount(input logic [63:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

  // Adds a and b, clamping at 2^width-1.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/stacker_row_mover.sv
// Sweeps the active block across the row: tick divider, position, direction
// and edge bounce. Spawn restarts the divider at the left edge moving right.
module stacker_row_mover #(
  parameter int COLS = 8,
  parameter int WW   = 4,
  parameter int DW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            en,
  input  logic            spawn,
  input  logic [WW-1:0]   w,
  input  logic [DW-1:0]   div,
  output logic [COLS-1:0] mask
);

  logic [WW-1:0] pos_q, pos_d, lim;
  logic          dir_q, dir_d;  // 0 = moving right, 1 = moving left
  logic [DW-1:0] cnt_q, cnt_d;

  assign lim = WW'(COLS) - w;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (spawn) begin
      pos_d = '0;
      dir_d = 1'b0;
      cnt_d = '0;
    end else if (en && tick) begin
      if (cnt_q + DW'(1) >= div) begin
        cnt_d = '0;
        // A full-width block has nowhere to go; otherwise bounce without dwell.
        if (lim != '0) begin
          if (!dir_q) begin
            if (pos_q == lim) begin
              dir_d = 1'b1;
              pos_d = pos_q - WW'(1);
            end else begin
              pos_d = pos_q + WW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = 1'b0;
              pos_d = pos_q + WW'(1);
            end else begin
              pos_d = pos_q - WW'(1);
            end
          end
        end
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
    end
  end

  assign mask = ~({COLS{1'b1}} << w) << (lim - pos_q);

endmodule

// File: rtl/game_stacker_gen.sv
// Stacker game core: owns the row stack, scoring, level and game FSM; the row mover sweeps the block.
// Define STACKER_PERFECT_BONUS_EN to award 2*w extra for an untrimmed placement above the bottom row.
module game_stacker_gen
  import stacker_pkg::*;
#(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int START_W  = 3,
  parameter int ID_W     = 16,
  parameter int SCORE_W  = 16,
  parameter int DIV_INIT = 8,
  parameter int DIV_MIN  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       place,
  input  logic [ID_W-1:0]            userid,
  input  logic [1:0]                 gamestate,
  output logic                       game_eog,
  output logic                       game_win,
  output logic [$clog2(ROWS+1)-1:0]  level,
  output logic [ROWS*COLS-1:0]       game_display,
  output logic [ID_W+SCORE_W-1:0]    game_data
);

  localparam int WW = $clog2(COLS + 1);
  localparam int DW = $clog2(DIV_INIT + 1);
  localparam int LW = $clog2(ROWS + 1);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e                  state_q, state_d;
  logic [COLS-1:0]         rows_q [ROWS];
  logic [COLS-1:0]         rows_d [ROWS];
  logic [AW-1:0]           act_q, act_d;
  logic [WW-1:0]           w_q, w_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    eog_q, eog_d, win_q, win_d, place_q;
  logic [ROWS*COLS-1:0]    disp_q, disp_d;
  logic [ID_W+SCORE_W-1:0] data_q;
  logic                    run, place_edge, spawn, mv_en, clear_rows;
  logic [COLS-1:0]         mask, below, overlap;
  logic [31:0]             pc, gain, bonus;
  logic [DW-1:0]           div;
  int                      div_i;

  assign run        = (gamestate == GS_RUN);
  assign place_edge = place & ~place_q;
  // A place edge freezes the block so PLACE sees the pre-tick mask.
  assign mv_en      = (state_q == SHIFT) && run && !place_edge;

  always_comb begin
    div_i = DIV_INIT - int'(level_q);
    if (div_i < DIV_MIN) div_i = DIV_MIN;
  end
  assign div = DW'(div_i);

  stacker_row_mover #(.COLS(COLS), .WW(WW), .DW(DW)) u_mover (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .en    (mv_en),
    .spawn (spawn),
    .w     (w_q),
    .div   (div),
    .mask  (mask)
  );

  always_comb begin
    below   = (act_q == AW'(ROWS - 1)) ? {COLS{1'b1}} : rows_q[act_q + AW'(1)];
    overlap = mask & below;
    pc      = popcount(64'(overlap));
    gain    = pc * (32'(level_q) + 32'd1);
    bonus   = '0;
`ifdef STACKER_PERFECT_BONUS_EN
    if ((overlap == mask) && (act_q != AW'(ROWS - 1))) bonus = pc << 1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    act_d      = act_q;
    w_d        = w_q;
    score_d    = score_q;
    level_d    = level_q;
    eog_d      = eog_q;
    win_d      = win_q;
    spawn      = 1'b0;
    clear_rows = 1'b0;
    case (state_q)
      IDLE: begin
        clear_rows = 1'b1;
        if (run) begin
          state_d = SHIFT;
          act_d   = AW'(ROWS - 1);
          w_d     = WW'(START_W);
          score_d = '0;
          level_d = '0;
          spawn   = 1'b1;
        end
      end
      SHIFT: begin
        if (!run) begin
          state_d    = IDLE;
          clear_rows = 1'b1;
        end else if (place_edge) begin
          state_d = PLACE;
        end
      end
      PLACE: begin
        if (!run) begin
          state_d    = IDLE;
          clear_rows = 1'b1;
        end else if (overlap == '0) begin
          state_d = EOG;
          eog_d   = 1'b1;
          win_d   = 1'b0;
        end else begin
          rows_d[act_q] = overlap;
          w_d           = WW'(pc);
          score_d       = SCORE_W'(sat_add(sat_add(32'(score_q), gain, SCORE_W), bonus, SCORE_W));
          level_d       = level_q + LW'(1);
          if (act_q == '0) begin
            state_d = EOG;
            eog_d   = 1'b1;
            win_d   = 1'b1;
          end else begin
            state_d = SHIFT;
            act_d   = act_q - AW'(1);
            spawn   = 1'b1;
          end
        end
      end
      EOG: begin
        if (gamestate == GS_MENU) begin
          state_d    = IDLE;
          eog_d      = 1'b0;
          win_d      = 1'b0;
          clear_rows = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_rows) begin
      for (int r = 0; r < ROWS; r++) rows_d[r] = '0;
    end
  end

  always_comb begin
    disp_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      disp_d[r*COLS +: COLS] = ((state_q == SHIFT || state_q == PLACE) && act_q == AW'(r))
                               ? mask : rows_q[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int r = 0; r < ROWS; r++) rows_q[r] <= '0;
      act_q   <= AW'(ROWS - 1);
      w_q     <= WW'(START_W);
      score_q <= '0;
      level_q <= '0;
      eog_q   <= 1'b0;
      win_q   <= 1'b0;
      place_q <= 1'b0;
      disp_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      act_q   <= act_d;
      w_q     <= w_d;
      score_q <= score_d;
      level_q <= level_d;
      eog_q   <= eog_d;
      win_q   <= win_d;
      place_q <= place;
      disp_q  <= disp_d;
      data_q  <= {userid, score_q};
    end
  end

  assign game_eog     = eog_q;
  assign game_win     = win_q;
  assign level        = level_q;
  assign game_display = disp_q;
  assign game_data    = data_q;

endmodule

// File: tb/tb_game_stacker_gen.sv
// Randomised scoreboard bench for game_stacker_gen: a behavioural game model predicts each
// placement outcome, a monitor compares it when level steps or game over rises.
module tb_game_stacker_gen;

  localparam int COLS = 8, ROWS = 8, START_W = 3, DIV_INIT = 8, DIV_MIN = 1;

  logic        clk, rst, tick, place;
  logic [15:0] userid;
  logic [1:0]  gamestate;
  logic        game_eog, game_win;
  logic [3:0]  level;
  logic [63:0] game_display;
  logic [31:0] game_data;

  game_stacker_gen dut (
    .clk(clk), .rst(rst), .tick(tick), .place(place), .userid(userid),
    .gamestate(gamestate), .game_eog(game_eog), .game_win(game_win), .level(level),
    .game_display(game_display), .game_data(game_data)
  );

  typedef struct {
    int        lvl;
    bit [31:0] data;
    bit        eog;
    bit        win;
    bit [63:0] disp;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0, total = 0;

  // Behavioural game model
  bit [7:0] m_rows [ROWS];
  int m_act, m_w, m_pos, m_dir, m_cnt, m_score, m_level;
  bit m_live;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [7:0] m_mask();
    return 8'(((1 << m_w) - 1) << (COLS - m_w - m_pos));
  endfunction

  function automatic bit [63:0] m_disp();
    bit [63:0] d;
    d = '0;
    for (int r = 0; r < ROWS; r++) d[r*8 +: 8] = (m_live && r == m_act) ? m_mask() : m_rows[r];
    return d;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
    m_live = 0;
  endtask

  task automatic m_spawn(input int act, input int w);
    m_act = act; m_w = w; m_pos = 0; m_dir = 1; m_cnt = 0; m_live = 1;
  endtask

  task automatic m_tick();
    int div, nxt;
    div = DIV_INIT - m_level;
    if (div < DIV_MIN) div = DIV_MIN;
    m_cnt++;
    if (m_cnt >= div) begin
      m_cnt = 0;
      if (m_w < COLS) begin
        nxt = m_pos + m_dir;
        if (nxt < 0 || nxt > COLS - m_w) begin
          m_dir = -m_dir;
          nxt = m_pos + m_dir;
        end
        m_pos = nxt;
      end
    end
  endtask

  task automatic m_place();
    bit [7:0] mk, bl, ov;
    int w;
    exp_t e;
    mk = m_mask();
    bl = (m_act == ROWS - 1) ? 8'hFF : m_rows[m_act + 1];
    ov = mk & bl;
    if (ov == 0) begin
      m_live = 0;
      e.eog = 1; e.win = 0;
    end else begin
      w = $countones(ov);
      m_rows[m_act] = ov;
      m_score += w * (m_level + 1);
`ifdef STACKER_PERFECT_BONUS_EN
      if (ov == mk && m_act != ROWS - 1) m_score += 2 * w;
`endif
      if (m_score > 65535) m_score = 65535;
      m_level++;
      if (m_act == 0) begin
        m_live = 0;
        e.eog = 1; e.win = 1;
      end else begin
        m_spawn(m_act - 1, w);
        e.eog = 0; e.win = 0;
      end
    end
    e.lvl  = m_level;
    e.data = {userid, 16'(m_score)};
    e.disp = m_disp();
    exp_q.push_back(e);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    m_tick();
    cyc();
    tick = 1'b0;
    repeat ($urandom_range(1, 2)) cyc();
  endtask

  task automatic do_place(input bit with_tick);
    tick  = with_tick;
    place = 1'b1;
    m_place();
    cyc();
    tick  = 1'b0;
    place = 1'b0;
    cyc();
  endtask

  task automatic settle();
    cyc();
    cyc();
  endtask

  task automatic start_game();
    userid    = 16'($urandom);
    gamestate = 2'b01;
    cyc();
    m_clear();
    m_score = 0;
    m_level = 0;
    m_spawn(ROWS - 1, START_W);
  endtask

  task automatic end_game();
    gamestate = 2'b00;
    settle();
    check("exit_eog", 64'(game_eog), 64'(0));
    check("exit_win", 64'(game_win), 64'(0));
    check("exit_display", game_display, 64'(0));
    m_clear();
  endtask

  // Monitor: a placement outcome is visible the cycle after level steps or game over rises.
  initial begin
    int   prev_lvl;
    bit   prev_eog;
    exp_t e;
    prev_lvl = 0;
    prev_eog = 0;
    forever begin
      @(negedge clk);
      if (!rst && (int'(level) == prev_lvl + 1 || (game_eog && !prev_eog))) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL sb_unexpected: level=%0d eog=%0b with no expected outcome", level, game_eog);
        end else begin
          e = exp_q.pop_front();
          check("sb_level", 64'(level), 64'(e.lvl));
          check("sb_data", 64'(game_data), 64'(e.data));
          check("sb_eog", 64'(game_eog), 64'(e.eog));
          check("sb_win", 64'(game_win), 64'(e.win));
          check("sb_display", game_display, e.disp);
        end
      end
      prev_lvl = int'(level);
      prev_eog = game_eog;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; tick = 1'b0; place = 1'b0; gamestate = 2'b00; userid = 16'h0;
    m_clear();
    #1 rst = 1'b1;
    #2;
    check("rst_eog", 64'(game_eog), 64'(0));
    check("rst_win", 64'(game_win), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_display", game_display, 64'(0));
    check("rst_data", 64'(game_data), 64'(0));
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Plan 1-3: immediate place, shifted trim, then a miss
    start_game();
    do_place(1'b0);
    settle();
    check("p1_score", 64'(game_data[15:0]), 64'(3));
    repeat (8) do_tick();
    check("p2_row6_shift", 64'(game_display[6*COLS +: COLS]), 64'(8'b01110000));
    do_place(1'b0);
    settle();
    check("p2_score", 64'(game_data[15:0]), 64'(7));
    repeat (36) do_tick();
    check("p3_row5_sweep", 64'(game_display[5*COLS +: COLS]), 64'(8'b00000011));
    do_place(1'b0);
    settle();
    check("p3_eog", 64'(game_eog), 64'(1));
    check("p3_win", 64'(game_win), 64'(0));
    end_game();

    // Level-0 speed, abort, and ignored place in IDLE
    start_game();
    repeat (7) do_tick();
    check("lvl0_hold", game_display, m_disp());
    do_tick();
    check("lvl0_move", game_display, m_disp());
    check("lvl0_row7", 64'(game_display[7*COLS +: COLS]), 64'(8'b01110000));
    gamestate = 2'b00;
    settle();
    m_clear();
    check("abort_display", game_display, 64'(0));
    check("abort_eog", 64'(game_eog), 64'(0));
    place = 1'b1; cyc(); place = 1'b0; settle();
    check("idle_place_level", 64'(level), 64'(0));
    check("idle_place_display", game_display, 64'(0));

    // Plan 4: every row aligned
    start_game();
    repeat (ROWS) begin
      do_place(1'b0);
      settle();
    end
    check("p4_win", 64'(game_win), 64'(1));
    check("p4_eog", 64'(game_eog), 64'(1));
`ifdef STACKER_PERFECT_BONUS_EN
    check("p4_score", 64'(game_data[15:0]), 64'(150));
`else
    check("p4_score", 64'(game_data[15:0]), 64'(108));
`endif
    end_game();

    // Plan 5: level-7 speed, then place together with a tick
    start_game();
    repeat (ROWS - 1) begin
      do_place(1'b0);
      settle();
    end
    repeat (2) begin
      do_tick();
      check("lvl7_move", game_display, m_disp());
    end
    do_place(1'b1);
    settle();
    check("p5_row0", 64'(game_display[0 +: COLS]), 64'(8'b00100000));
    end_game();

    // Plan 6: asynchronous reset mid-SHIFT
    start_game();
    repeat (5) do_tick();
    #2 rst = 1'b1;
    #1;
    check("arst_display", game_display, 64'(0));
    check("arst_data", 64'(game_data), 64'(0));
    check("arst_level", 64'(level), 64'(0));
    gamestate = 2'b00;
    m_clear();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc();
    check("arst_idle_display", game_display, 64'(0));
    check("arst_idle_eog", 64'(game_eog), 64'(0));

    // Randomised games
    for (int g = 0; g < 5; g++) begin
      start_game();
      while (m_live) begin
        repeat ($urandom_range(0, 14)) do_tick();
        do_place($urandom_range(0, 3) == 0);
        settle();
      end
      end_game();
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    check("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/game_stacker_gen.md
Name: game_stacker_gen

Overview:
Parametrised next-generation Stacker game core. A block of configurable width sweeps back and forth across a COLS-wide row. On a button press the block locks onto the stack and any overhang is trimmed, so the block narrows. Block speed rises with level. Sits beside the menu/score logic and drives the LED-matrix display bus and the {userid, score} record.

Parameters:
COLS, 8, row width in cells
ROWS, 8, stack height; row ROWS-1 is the bottom row, row 0 is the top row
START_W, 3, initial block width (1..COLS)
ID_W, 16, userid width
SCORE_W, 16, score width
DIV_INIT, 8, ticks per move step at level 0
DIV_MIN, 1, minimum ticks per move step

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  single-cycle movement time base pulse
place  in  1  place button (level; rising edge detected internally)
userid  in  ID_W  player id
gamestate  in  2  2'b01 = start/run, 2'b00 = menu
game_eog  out  1  game over flag
game_win  out  1  set with game_eog when the top row is placed
level  out  $clog2(ROWS+1)  rows placed so far
game_display  out  ROWS*COLS  row ROWS-1 at the MSBs down to row 0 at the LSBs; bit MSB of a row = leftmost cell
game_data  out  ID_W+SCORE_W  {userid, score}

Behaviour:
- rst: state IDLE, all rows 0, score 0, level 0, game_eog 0, game_win 0, place-edge register 0. Reset takes effect immediately, including mid-game.
- IDLE: rows cleared. When gamestate==01, load the bottom row with START_W ones left-justified, set w=START_W, direction=right, and go to SHIFT.
- SHIFT: the active row moves one cell per DIV ticks, where DIV = max(DIV_MIN, DIV_INIT-level).
  - The tick divider restarts at each spawn.
  - At an edge, direction flips and the block moves one cell in the new direction on the same step (no dwell).
- Place edge in SHIFT goes to PLACE. On a cycle with both place and a due tick, place wins and the position is not moved. Place edges outside SHIFT are ignored.
- PLACE (1 cycle):
  - Bottom row: overlap = active row. Other rows: overlap = active & row below.
  - overlap==0: clear the active row and go to EOG with win=0.
  - Otherwise:
    - row := overlap; w := popcount(overlap).
    - score += w*(level+1), using the pre-increment level; score saturates at 2^SCORE_W-1.
    - level += 1.
  - If the placed row was row 0: go to EOG with win=1.
  - Else: spawn the next row up with w ones left-justified, direction right, and go to SHIFT.
- EOG: game_eog=1 and game_win held; display and score frozen. Return to IDLE when gamestate==00; flags clear on the exit to IDLE.
- gamestate leaving 01 during SHIFT/PLACE: abort to IDLE with no EOG.
- All outputs are registered; game_data and game_display update the cycle after the state change.

Optional Feature:
STACKER_PERFECT_BONUS_EN
- Defined: a placement with overlap == active row (no trim, not on the bottom row) adds an extra 2*w to the score (saturating).
- Undefined: no bonus; scoring is exactly as in Behaviour.

Decomposition:
- Package stacker_pkg holds:
  - state enum {IDLE, SHIFT, PLACE, EOG}
  - GS_RUN=2'b01 and GS_MENU=2'b00
  - the popcount function
  - the saturating-add function
- Sub-module stacker_row_mover holds the tick divider, position, direction and bounce. It outputs the active row mask for a given w; the top level owns the row array, scoring and FSM.

Test Plan:
1. Defaults, gamestate=01, place immediately -> bottom row 11100000 locked, score 3, level 1, row 6 = 11100000.
2. Then 8 ticks give row6 = 01110000; place -> row6 = 01100000, w=2, score 7, row 5 = 11000000.
3. Row 5 swept to 00000011 with row 6 = 01100000, place -> game_eog=1, game_win=0, score 7, row 5 = 0; then gamestate=00 -> IDLE, flags 0.
4. Every placement aligned over 8 rows -> game_win=1, game_eog=1, score 108. With STACKER_PERFECT_BONUS_EN defined, score 150.
5. Speed check: at level 0, position changes every 8th tick; at level 7, every tick; one cycle with place and a tick together -> position unchanged and placement used the pre-tick mask.
6. rst asserted mid-SHIFT without a clock edge -> all outputs 0 immediately; after release the block stays in IDLE until gamestate==01.
